edge_mask_loader: RTL and testbench
===================================

Name: edge_mask_loader

Overview:
- Write-side counterpart to the edge-mask table read by the primitive checker.
- Accepts a narrow 32-bit word stream over a valid/ready handshake and assembles each group of 64 words into one 2048-bit mask line.
- Writes each completed line into the mask block RAM at sequential {x,y,z} addresses (write port of the table the checker reads).
- Used to (re)load the table at run time instead of relying on a fixed ROM init image.

Parameters:
- DATA_W, 32, stream word width.
- LINE_W, 2048, mask line width. Must be an integer multiple of DATA_W.
- ADDR_W, 12, table address width, i.e. {x[3:0],y[3:0],z[3:0]}.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse that begins a load. Ignored while busy=1.
- start_addr  in  ADDR_W  first table address. Sampled on an accepted start.
- end_addr  in  ADDR_W  last table address, inclusive. Sampled on an accepted start.
- s_data  in  DATA_W  stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data.
- wea  out  1  BRAM write enable, one-cycle pulse per line.
- addra  out  ADDR_W  BRAM write address.
- dina  out  LINE_W  BRAM write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse after the last line is written.
- lines_written  out  ADDR_W+1  lines written in the current or last load.

Behaviour:
- Reset (RST_n=0, asynchronous) forces:
  - state IDLE.
  - s_ready=0, wea=0, busy=0, done=0.
  - addra=0, dina=0, lines_written=0, word counter=0.
  - Any partial line is discarded.
- WPL = LINE_W/DATA_W (64 at defaults). Word counter width is log2(WPL).
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 does all of the following: latch addra<=start_addr and end_addr, clear the word counter, clear lines_written, go to FILL.
- FILL:
  - busy=1, s_ready=1.
  - A beat is accepted when s_valid && s_ready. Word k of a line goes to dina[k*DATA_W +: DATA_W]; word 0 is the LSBs.
  - On acceptance of word WPL-1, go to WRITE. The counter wraps to 0.
  - s_valid low simply stalls. There is no timeout.
- WRITE (exactly one cycle):
  - s_ready=0, wea=1; addra and dina are stable.
  - lines_written increments.
  - If addra==latched end_addr, go to DONE.
  - Otherwise addra <= addra+1 modulo 2^ADDR_W, then go to FILL. 4095 wraps to 0, so end_addr<start_addr is a legal wrap-around load.
- DONE (one cycle):
  - done=1, busy stays 1, s_ready=0.
  - Next state IDLE. addra holds the last written address.
- Timing and throughput:
  - Minimum cost is WPL+1 cycles per line: WPL accept cycles plus 1 write cycle.
  - Exactly one bubble on s_ready per line.
- Counts:
  - start_addr==end_addr loads one line.
  - A full-table load (start=0, end=4095) writes 4096 lines; lines_written=4096 needs the extra bit.
- Ignored inputs:
  - start asserted in any state other than IDLE has no effect.
  - s_valid in IDLE or DONE is not consumed.
- dina is not cleared between lines. Every bit is overwritten before the next wea, so no stale data is written.
- Downstream constraint: the checker must not read the table while busy=1. The loader does not arbitrate.
- Reset mid-load:
  - Lines already written remain in the BRAM.
  - No wea is issued after reset asserts.
  - done is not pulsed.

Test Plan:
- Single line: start with start_addr=end_addr=0x123, then 64 words 0..63 with s_valid held high. Required:
  - s_ready high for 64 cycles.
  - Exactly one wea, with addra=0x123 and dina[k*32+:32]=k.
  - done pulses 1 cycle later; lines_written=1.
- Back-to-back lines: start=0x000, end=0x002, 192 words. Required:
  - wea at addra 0,1,2, spaced 65 cycles apart.
  - One s_ready low cycle per line; done once; lines_written=3.
- Wrap-around: start=0xFFF, end=0x001. Required:
  - Writes at 0xFFF, 0x000, 0x001; lines_written=3.
- Throttled stream: s_valid toggles 1/0 for each word of one line. Required:
  - dina is correct.
  - wea asserts only after the 64th accepted beat.
  - No word is duplicated or dropped.
- Ignored start and mid-load reset:
  - start pulse during FILL -> no effect on addra or counters.
  - RST_n low after 30 words of line 2 -> wea and busy go 0 asynchronously, no done pulse.
  - After release, a new start at 0x010 -> writes 0x010 with fresh data.
- Full table: start=0x000, end=0xFFF with continuous words. Required:
  - 4096 wea pulses; lines_written=4096.
  - done exactly 4096*65+1 cycles after the start cycle.

Source files
------------

// File: rtl/edge_mask_loader.sv
// rtl/edge_mask_loader.sv - assembles a 32-bit word stream into mask lines and writes them to the edge-mask table
module edge_mask_loader #(
  parameter int DATA_W = 32,
  parameter int LINE_W = 2048,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [LINE_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   lines_written
);

  localparam int WPL   = LINE_W / DATA_W;
  localparam int CNT_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPL - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic [ADDR_W-1:0] end_q;
  logic              accept;
  logic              last_addr;

  // A beat only lands while filling; last_addr ends the load after this line's write.
  assign accept    = (state == FILL) && s_valid;
  assign last_addr = (addra == end_q);

  // State register; reset abandons any load in progress, including a partial line.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    wea       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid && (word_cnt == LAST_WORD)) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        wea       = 1'b1;
        state_nxt = last_addr ? DONE : FILL;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the address window, pack words LSB-first, advance the address after each write.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      addra         <= '0;
      end_q         <= '0;
      dina          <= '0;
      word_cnt      <= '0;
      lines_written <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addra         <= start_addr;
            end_q         <= end_addr;
            word_cnt      <= '0;
            lines_written <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            // dina is never cleared: every slot is rewritten before the next wea.
            for (int k = 0; k < WPL; k++) begin
              if (word_cnt == CNT_W'(k)) dina[k*DATA_W +: DATA_W] <= s_data;
            end
            word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          lines_written <= lines_written + (ADDR_W+1)'(1);
          // Natural wrap of addra makes end_addr < start_addr a legal wrap-around load.
          if (!last_addr) addra <= addra + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_mask_loader.sv
// tb/tb_edge_mask_loader.sv - scoreboard bench for edge_mask_loader against a line-level reference model
module tb_edge_mask_loader;

  localparam int DATA_W  = 32;
  localparam int LINE_W  = 2048;
  localparam int ADDR_W  = 12;
  localparam int WPL     = LINE_W / DATA_W;
  localparam int LINE_W2 = 64;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } line_t;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready, wea, busy, done;
  logic [ADDR_W-1:0] addra;
  logic [LINE_W-1:0] dina;
  logic [ADDR_W:0]   lines_written;

  logic               start2 = 1'b0;
  logic [ADDR_W-1:0]  start_addr2 = '0;
  logic [ADDR_W-1:0]  end_addr2 = '1;
  logic [DATA_W-1:0]  s_data2 = '0;
  logic               s_valid2 = 1'b0;
  logic               s_ready2, wea2, busy2, done2;
  logic [ADDR_W-1:0]  addra2;
  logic [LINE_W2-1:0] dina2;
  logic [ADDR_W:0]    lines_written2;

  edge_mask_loader #(.DATA_W(DATA_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .wea(wea), .addra(addra),
    .dina(dina), .busy(busy), .done(done), .lines_written(lines_written)
  );

  // Two-word lines so a complete 4096-line table load fits in a short run.
  edge_mask_loader #(.DATA_W(DATA_W), .LINE_W(LINE_W2), .ADDR_W(ADDR_W)) dut2 (
    .CLK(CLK), .RST_n(RST_n), .start(start2), .start_addr(start_addr2), .end_addr(end_addr2),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2), .wea(wea2), .addra(addra2),
    .dina(dina2), .busy(busy2), .done(done2), .lines_written(lines_written2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  line_t sb_q[$];
  line_t mon_e;
  int    wea_cyc_q[$];
  int    wea_cnt = 0, done_cnt = 0, ready_hi = 0, busy_nrdy = 0;
  int    last_wea_cyc = -10, done_cyc = 0;
  bit    found;

  // Monitor: every write is popped against the reference queue; done must follow the last write.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (s_ready) ready_hi++;
      if (busy && !s_ready) busy_nrdy++;
      if (wea) begin
        wea_cnt++;
        last_wea_cyc = cyc;
        wea_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_wea", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("wea_addr", 64'(addra), 64'(mon_e.addr));
          n_chk++;
          if (dina !== mon_e.data) begin
            n_fail++;
            found = 1'b0;
            for (int k = 0; k < WPL; k++) begin
              if (!found && (dina[k*DATA_W +: DATA_W] !== mon_e.data[k*DATA_W +: DATA_W])) begin
                found = 1'b1;
                $display("FAIL wea_dina word %0d: got %h, required %h", k,
                         dina[k*DATA_W +: DATA_W], mon_e.data[k*DATA_W +: DATA_W]);
              end
            end
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_last_wea", 64'(cyc - last_wea_cyc), 64'd1);
      end
    end
  end

  int wea2_cnt = 0, done2_cnt = 0, done2_cyc = 0;
  logic [ADDR_W-1:0] exp2_addr = '0;

  // Full-table monitor: addresses must walk 0..4095 in order.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (wea2) begin
        check("full_wea_addr", 64'(addra2), 64'(exp2_addr));
        exp2_addr = exp2_addr + 1'b1;
        wea2_cnt++;
      end
      if (done2) begin
        done2_cnt++;
        done2_cyc = cyc;
      end
    end
  end

  // Issue one load; every completed line is pushed to the scoreboard as address (sa + line index) mod 4096.
  task automatic run_load(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                          input bit throttle, input bit idx_data, input int abort_at,
                          input int ign_at, output int start_cyc, output int last_acc_cyc);
    int nlines = ((int'(ea) - int'(sa) + 4096) % 4096) + 1;
    int total  = nlines * WPL;
    int acc    = 0;
    int budget = total * 3 + 100;
    bit v      = 1'b0;
    bit rdy;
    logic [DATA_W-1:0] w;
    logic [LINE_W-1:0] line_img = '0;
    line_t e;
    last_acc_cyc = -1;
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge CLK); #1;
    start      = 1'b0;
    start_addr = 12'($urandom);
    end_addr   = 12'($urandom);
    w = idx_data ? '0 : $urandom;
    while (acc < total && budget > 0) begin
      if (acc == abort_at) break;
      v = throttle ? ~v : 1'b1;
      s_valid = v;
      s_data  = w;
      if (acc == ign_at && s_ready) begin
        start      = 1'b1;
        start_addr = 12'h300;
        end_addr   = 12'h300;
      end
      rdy = s_ready;
      @(posedge CLK);
      if (v && rdy) begin
        line_img[(acc % WPL)*DATA_W +: DATA_W] = w;
        if (acc % WPL == WPL - 1) begin
          e.addr = sa + 12'(acc / WPL);
          e.data = line_img;
          sb_q.push_back(e);
        end
        last_acc_cyc = cyc;
        acc++;
        w = idx_data ? 32'(acc % WPL) : $urandom;
      end
      #1;
      start = 1'b0;
      budget--;
    end
    if (abort_at < 0) s_valid = 1'b0;
    if (budget == 0) check("stream_budget", 64'(acc), 64'(total));
  endtask

  task automatic wait_done(input int d0);
    int b = 0;
    while (done_cnt == d0 && b < 20) begin
      @(posedge CLK); #1;
      b++;
    end
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  int sc, la, d0, w0, b;

  initial begin
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addra", 64'(addra), 64'd0);
    check("rst_dina_zero", 64'(dina == '0), 64'd1);
    check("rst_lines_written", 64'(lines_written), 64'd0);
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Single line, word k carries value k.
    ready_hi = 0; d0 = done_cnt; w0 = wea_cnt;
    run_load(12'h123, 12'h123, 1'b0, 1'b1, -1, -1, sc, la);
    wait_done(d0);
    check("t1_ready_cycles", 64'(ready_hi), 64'd64);
    check("t1_wea_count", 64'(wea_cnt - w0), 64'd1);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_lines_written", 64'(lines_written), 64'd1);
    check("t1_wea_after_last_beat", 64'(last_wea_cyc), 64'(la + 1));
    check("t1_busy_idle", 64'(busy), 64'd0);

    // Three back-to-back lines.
    ready_hi = 0; busy_nrdy = 0; d0 = done_cnt; w0 = wea_cnt; wea_cyc_q.delete();
    run_load(12'h000, 12'h002, 1'b0, 1'b0, -1, -1, sc, la);
    wait_done(d0);
    check("t2_wea_count", 64'(wea_cnt - w0), 64'd3);
    check("t2_ready_cycles", 64'(ready_hi), 64'd192);
    check("t2_ready_bubbles", 64'(busy_nrdy), 64'd4);
    check("t2_done_count", 64'(done_cnt - d0), 64'd1);
    check("t2_lines_written", 64'(lines_written), 64'd3);
    check("t2_done_latency", 64'(done_cyc - sc), 64'd196);
    if (wea_cyc_q.size() == 3) begin
      check("t2_spacing_1", 64'(wea_cyc_q[1] - wea_cyc_q[0]), 64'd65);
      check("t2_spacing_2", 64'(wea_cyc_q[2] - wea_cyc_q[1]), 64'd65);
    end else begin
      check("t2_wea_cycle_log", 64'(wea_cyc_q.size()), 64'd3);
    end

    // Wrap-around through 0xFFF.
    d0 = done_cnt; w0 = wea_cnt;
    run_load(12'hFFF, 12'h001, 1'b0, 1'b0, -1, -1, sc, la);
    wait_done(d0);
    check("t3_wea_count", 64'(wea_cnt - w0), 64'd3);
    check("t3_lines_written", 64'(lines_written), 64'd3);
    check("t3_last_addra", 64'(addra), 64'h001);

    // Throttled stream, s_valid alternating.
    d0 = done_cnt; w0 = wea_cnt;
    run_load(12'h0A5, 12'h0A5, 1'b1, 1'b0, -1, -1, sc, la);
    wait_done(d0);
    check("t4_wea_count", 64'(wea_cnt - w0), 64'd1);
    check("t4_wea_after_last_beat", 64'(last_wea_cyc), 64'(la + 1));
    check("t4_lines_written", 64'(lines_written), 64'd1);

    // Ignored start in FILL, then reset 30 words into line 2.
    d0 = done_cnt; w0 = wea_cnt;
    run_load(12'h040, 12'h043, 1'b0, 1'b0, WPL + 30, 10, sc, la);
    check("t5_lines_before_reset", 64'(lines_written), 64'd1);
    check("t5_busy_before_reset", 64'(busy), 64'd1);
    RST_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_wea", 64'(wea), 64'd0);
    check("t5_rst_s_ready", 64'(s_ready), 64'd0);
    check("t5_rst_lines_written", 64'(lines_written), 64'd0);
    s_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    check("t5_wea_count", 64'(wea_cnt - w0), 64'd1);
    d0 = done_cnt; w0 = wea_cnt;
    run_load(12'h010, 12'h010, 1'b0, 1'b0, -1, -1, sc, la);
    wait_done(d0);
    check("t5_reload_wea_count", 64'(wea_cnt - w0), 64'd1);
    check("t5_reload_lines_written", 64'(lines_written), 64'd1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    // Full table on the two-word-line instance.
    start2 = 1'b1;
    sc = cyc;
    @(posedge CLK); #1;
    start2 = 1'b0;
    s_valid2 = 1'b1;
    b = 0;
    while (done2_cnt == 0 && b < 4096 * 3 + 50) begin
      s_data2 = $urandom;
      @(posedge CLK); #1;
      b++;
    end
    s_valid2 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("t6_done_count", 64'(done2_cnt), 64'd1);
    check("t6_wea_count", 64'(wea2_cnt), 64'd4096);
    check("t6_lines_written", 64'(lines_written2), 64'd4096);
    check("t6_done_latency", 64'(done2_cyc - sc), 64'(4096 * 3 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
